// File: rtl/uart_rx_config_if.sv
// Serial receive bundle: raw line into the receiver, frame word and status flags out.
`timescale 1ns/1ps
interface uart_rx_config_if #(
  parameter int BITS_DADOS = 8
);
  logic                  bitSerialAtual;
  logic                  bitsEstaoRecebidos;
  logic [BITS_DADOS-1:0] byteCompleto;
  logic                  erroParidade;
  logic                  erroQuadro;
  logic                  quebraDetectada;

  modport master (
    input  bitSerialAtual,
    output bitsEstaoRecebidos,
    output byteCompleto,
    output erroParidade,
    output erroQuadro,
    output quebraDetectada
  );

  modport slave (
    output bitSerialAtual,
    input  bitsEstaoRecebidos,
    input  byteCompleto,
    input  erroParidade,
    input  erroQuadro,
    input  quebraDetectada
  );
endinterface

// File: rtl/uart_rx_config.sv
// Configurable UART receiver: 5..9 data bits, optional odd/even parity, 1 or 2 stop bits,
// with parity, framing and break reporting on a one-cycle frame-complete pulse.
`timescale 1ns/1ps
module uart_rx_config #(
  parameter int CLOCKS_POR_BIT = 5209,
  parameter int BITS_DADOS     = 8,
  parameter int PARIDADE       = 0,
  parameter int BITS_PARADA    = 1
) (
  input  logic               clock,
  input  logic               reset,
  uart_rx_config_if.master   rx
);

  localparam int CW = $clog2(CLOCKS_POR_BIT);
  localparam int IW = (BITS_DADOS > 1) ? $clog2(BITS_DADOS) : 1;
  localparam logic [CW-1:0] CNT_FIM        = CW'(CLOCKS_POR_BIT - 1);
  localparam logic [CW-1:0] CNT_MEIO       = CW'((CLOCKS_POR_BIT - 1) / 2);
  localparam logic [IW-1:0] IDX_DADOS_FIM  = IW'(BITS_DADOS - 1);
  localparam logic [IW-1:0] IDX_PARADA_FIM = IW'(BITS_PARADA - 1);
  localparam logic          PAR_ALVO       = (PARIDADE == 1);

  typedef enum logic [2:0] {
    ESPERA      = 3'd0,
    INICIO      = 3'd1,
    DADOS       = 3'd2,
    PARIDADE_ST = 3'd3,
    PARADA      = 3'd4,
    LIMPEZA     = 3'd5,
    ESPERA_ALTA = 3'd6
  } estado_t;

  estado_t               estado;
  logic [CW-1:0]         contador;
  logic [IW-1:0]         indice;
  logic [BITS_DADOS-1:0] regDados;
  logic                  acumParidade;
  logic                  pendErroPar;
  logic                  pendQuadro;
  logic                  pendZero;
  logic                  pulso;
  logic [BITS_DADOS-1:0] byteReg;
  logic                  erroParReg;
  logic                  erroQuadroReg;
  logic                  quebraReg;
  logic                  sinc_p0;
  logic                  linha_p1;
  logic                  fimBit;

  // Parity check: data XOR parity sample must equal 1 for odd, 0 for even.
  function automatic logic erroParidadeCalc(input logic acumulado, input logic amostra);
    return (acumulado ^ amostra) != PAR_ALVO;
  endfunction

  // stage p0/p1: two-flop synchroniser for the asynchronous serial pin
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sinc_p0  <= 1'b1;
      linha_p1 <= 1'b1;
    end else begin
      sinc_p0  <= rx.bitSerialAtual;
      linha_p1 <= sinc_p0;
    end
  end

  assign fimBit = (contador == CNT_FIM);

  // Data bits arrive LSB first, so shifting in at the top leaves bit 0 at the bottom.
  always_ff @(posedge clock) begin
    if (estado == DADOS && fimBit)
      regDados <= {linha_p1, regDados[BITS_DADOS-1:1]};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado        <= ESPERA;
      contador      <= '0;
      indice        <= '0;
      acumParidade  <= 1'b0;
      pendErroPar   <= 1'b0;
      pendQuadro    <= 1'b0;
      pendZero      <= 1'b1;
      pulso         <= 1'b0;
      byteReg       <= '0;
      erroParReg    <= 1'b0;
      erroQuadroReg <= 1'b0;
      quebraReg     <= 1'b0;
    end else begin
      pulso <= 1'b0;
      case (estado)
        ESPERA: begin
          contador     <= '0;
          indice       <= '0;
          acumParidade <= 1'b0;
          pendErroPar  <= 1'b0;
          pendQuadro   <= 1'b0;
          pendZero     <= 1'b1;
          if (!linha_p1)
            estado <= INICIO;
        end
        INICIO: begin
          if (contador == CNT_MEIO) begin
            contador <= '0;
            estado   <= linha_p1 ? ESPERA : DADOS;
          end else begin
            contador <= contador + CW'(1);
          end
        end
        DADOS: begin
          if (fimBit) begin
            contador     <= '0;
            acumParidade <= acumParidade ^ linha_p1;
            pendZero     <= pendZero & ~linha_p1;
            if (indice == IDX_DADOS_FIM) begin
              indice <= '0;
              estado <= (PARIDADE != 0) ? PARIDADE_ST : PARADA;
            end else begin
              indice <= indice + IW'(1);
            end
          end else begin
            contador <= contador + CW'(1);
          end
        end
        PARIDADE_ST: begin
          if (fimBit) begin
            contador    <= '0;
            pendErroPar <= erroParidadeCalc(acumParidade, linha_p1);
            pendZero    <= pendZero & ~linha_p1;
            estado      <= PARADA;
          end else begin
            contador <= contador + CW'(1);
          end
        end
        PARADA: begin
          if (fimBit) begin
            contador <= '0;
            if (indice == IDX_PARADA_FIM) begin
              // The final stop sample is folded straight into the published flags.
              indice        <= '0;
              byteReg       <= regDados;
              erroParReg    <= pendErroPar;
              erroQuadroReg <= pendQuadro | ~linha_p1;
              quebraReg     <= pendZero & ~linha_p1;
              pulso         <= 1'b1;
              estado        <= LIMPEZA;
            end else begin
              indice     <= indice + IW'(1);
              pendQuadro <= pendQuadro | ~linha_p1;
              pendZero   <= pendZero & ~linha_p1;
            end
          end else begin
            contador <= contador + CW'(1);
          end
        end
        LIMPEZA: begin
          estado <= quebraReg ? ESPERA_ALTA : ESPERA;
        end
        ESPERA_ALTA: begin
          // A held-low line must go idle before another start bit is accepted.
          if (linha_p1)
            estado <= ESPERA;
        end
        default: estado <= ESPERA;
      endcase
    end
  end

  assign rx.bitsEstaoRecebidos = pulso;
  assign rx.byteCompleto       = byteReg;
  assign rx.erroParidade       = erroParReg;
  assign rx.erroQuadro         = erroQuadroReg;
  assign rx.quebraDetectada    = quebraReg;

endmodule

// File: tb/tb_uart_rx_config.sv
// Randomised bench for uart_rx_config: an 8N1 instance and a 7E2 instance, checked against a frame-level model.
`timescale 1ns/1ps
module tb_uart_rx_config;
  localparam int CPB   = 16;
  localparam int PAR_B = 2;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  uart_rx_config_if #(.BITS_DADOS(8)) rxA ();
  uart_rx_config_if #(.BITS_DADOS(7)) rxB ();

  uart_rx_config #(.CLOCKS_POR_BIT(CPB), .BITS_DADOS(8), .PARIDADE(0), .BITS_PARADA(1)) dutA (
    .clock(clock), .reset(reset), .rx(rxA.master));
  uart_rx_config #(.CLOCKS_POR_BIT(CPB), .BITS_DADOS(7), .PARIDADE(PAR_B), .BITS_PARADA(2)) dutB (
    .clock(clock), .reset(reset), .rx(rxB.master));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int pulsesA = 0, pulsesB = 0, lastCycA = 0, lastCycB = 0, widthErr = 0;
  logic prevA = 1'b0, prevB = 1'b0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (rxA.bitsEstaoRecebidos) begin
      pulsesA  <= pulsesA + 1;
      lastCycA <= cyc;
      if (prevA) widthErr <= widthErr + 1;
    end
    if (rxB.bitsEstaoRecebidos) begin
      pulsesB  <= pulsesB + 1;
      lastCycB <= cyc;
      if (prevB) widthErr <= widthErr + 1;
    end
    prevA <= rxA.bitsEstaoRecebidos;
    prevB <= rxB.bitsEstaoRecebidos;
  end

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic setLine(input int inst, input logic b);
    if (inst == 0) rxA.bitSerialAtual = b;
    else           rxB.bitSerialAtual = b;
  endtask

  function automatic int pulsesOf(input int inst);
    return (inst == 0) ? pulsesA : pulsesB;
  endfunction

  // Frame-level model: expectations come from the bits placed on the line.
  task automatic runFrame(input int inst, input string tag, input logic [8:0] data,
                          input logic pbit, input logic [1:0] stops, input int idleBits);
    int   nData  = (inst == 0) ? 8 : 7;
    int   nStop  = (inst == 0) ? 1 : 2;
    logic hasPar = (inst == 1);
    logic dx     = 1'b0;
    logic expFr  = 1'b0;
    logic allZ   = 1'b1;
    logic expPar;
    int   nBits, expLat, lat, p0, startCyc;
    logic [8:0] mask;
    logic [31:0] oByte, oPar, oFr, oBrk;
    bit q[$];
    mask = 9'((1 << nData) - 1);
    for (int i = 0; i < nData; i++) begin
      dx = dx ^ data[i];
      if (data[i]) allZ = 1'b0;
    end
    expPar = hasPar ? ((dx ^ pbit) != (PAR_B == 1)) : 1'b0;
    if (hasPar && pbit) allZ = 1'b0;
    for (int s = 0; s < nStop; s++) begin
      if (!stops[s]) expFr = 1'b1;
      else           allZ  = 1'b0;
    end
    q.push_back(1'b0);
    for (int i = 0; i < nData; i++) q.push_back(data[i]);
    if (hasPar) q.push_back(pbit);
    for (int s = 0; s < nStop; s++) q.push_back(stops[s]);
    nBits  = q.size();
    expLat = 2 + (CPB - 1) / 2 + 1 + (nBits - 1) * CPB + 1;
    p0 = pulsesOf(inst);
    startCyc = cyc;
    foreach (q[i]) begin
      setLine(inst, q[i]);
      waitCycles(CPB);
    end
    setLine(inst, 1'b1);
    if (idleBits > 0) waitCycles(idleBits * CPB);
    if (inst == 0) begin
      oByte = 32'(rxA.byteCompleto); oPar = 32'(rxA.erroParidade);
      oFr = 32'(rxA.erroQuadro); oBrk = 32'(rxA.quebraDetectada); lat = lastCycA - startCyc;
    end else begin
      oByte = 32'(rxB.byteCompleto); oPar = 32'(rxB.erroParidade);
      oFr = 32'(rxB.erroQuadro); oBrk = 32'(rxB.quebraDetectada); lat = lastCycB - startCyc;
    end
    checkVal({tag, ".pulses"}, 32'(pulsesOf(inst) - p0), 32'd1);
    checkVal({tag, ".byte"}, oByte, 32'(data & mask));
    checkVal({tag, ".par"}, oPar, 32'(expPar));
    checkVal({tag, ".frame"}, oFr, 32'(expFr));
    checkVal({tag, ".break"}, oBrk, 32'(allZ));
    checkVal({tag, ".latency"}, (lat >= expLat - 1 && lat <= expLat + 1) ? 32'(expLat) : 32'(lat),
             32'(expLat));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout: cyc=%0d required finish", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin
    int p0, pB;
    logic [8:0] d;
    logic pb;
    logic [1:0] st;
    int inst, idle;
    rxA.bitSerialAtual = 1'b1;
    rxB.bitSerialAtual = 1'b1;
    #2 reset = 1'b1;
    waitCycles(4);
    reset = 1'b0;
    waitCycles(4);
    checkVal("rst.pulseA", 32'(rxA.bitsEstaoRecebidos), 32'd0);
    checkVal("rst.byteA", 32'(rxA.byteCompleto), 32'd0);
    checkVal("rst.flagsA", {29'd0, rxA.erroParidade, rxA.erroQuadro, rxA.quebraDetectada}, 32'd0);
    checkVal("rst.byteB", 32'(rxB.byteCompleto), 32'd0);
    checkVal("rst.flagsB", {29'd0, rxB.erroParidade, rxB.erroQuadro, rxB.quebraDetectada}, 32'd0);

    runFrame(0, "a5", 9'h0A5, 1'b0, 2'b11, 2);
    runFrame(1, "par0", 9'h003, 1'b0, 2'b11, 2);
    runFrame(1, "par1", 9'h003, 1'b1, 2'b11, 2);
    runFrame(0, "stop0", 9'h055, 1'b0, 2'b00, 2);
    runFrame(0, "stopok", 9'h055, 1'b0, 2'b11, 2);

    // short low glitch must not start a frame
    p0 = pulsesA;
    setLine(0, 1'b0);
    waitCycles(4);
    setLine(0, 1'b1);
    waitCycles(3 * CPB);
    checkVal("glitch.pulses", 32'(pulsesA - p0), 32'd0);
    runFrame(0, "3c", 9'h03C, 1'b0, 2'b11, 2);

    // line held low: exactly one break frame, none repeated
    p0 = pulsesA;
    setLine(0, 1'b0);
    waitCycles(20 * CPB);
    checkVal("brk.pulses", 32'(pulsesA - p0), 32'd1);
    checkVal("brk.byte", 32'(rxA.byteCompleto), 32'd0);
    checkVal("brk.break", 32'(rxA.quebraDetectada), 32'd1);
    checkVal("brk.frame", 32'(rxA.erroQuadro), 32'd1);
    setLine(0, 1'b1);
    waitCycles(2 * CPB);
    checkVal("brk.after", 32'(pulsesA - p0), 32'd1);
    runFrame(0, "81", 9'h081, 1'b0, 2'b11, 2);

    for (int n = 0; n < 16; n++) begin
      inst = $urandom_range(0, 1);
      d  = 9'($urandom_range(0, 255));
      st = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
      if (inst == 0) st[1] = 1'b1;
      if ($urandom_range(0, 7) == 0) begin
        d  = 9'd0;
        st = 2'b00;
      end
      pb = (^d[6:0]) ^ ($urandom_range(0, 3) == 0);
      if (d == 9'd0 && st == 2'b00) pb = 1'b0;
      idle = (st == 2'b11 && $urandom_range(0, 1) == 0) ? 0 : 1;
      runFrame(inst, (inst == 0) ? "rndA" : "rndB", d, pb, st, idle);
    end

    // reset during data bit 3 of a 0x81 frame
    runFrame(1, "preB", 9'h055, 1'b1, 2'b11, 1);
    p0 = pulsesA;
    pB = pulsesB;
    setLine(0, 1'b0);
    waitCycles(CPB);
    setLine(0, 1'b1);
    waitCycles(CPB);
    setLine(0, 1'b0);
    waitCycles(2 * CPB + 8);
    reset = 1'b1;
    #1;
    checkVal("arst.byteA", 32'(rxA.byteCompleto), 32'd0);
    checkVal("arst.flagsA", {29'd0, rxA.erroParidade, rxA.erroQuadro, rxA.quebraDetectada}, 32'd0);
    checkVal("arst.byteB", 32'(rxB.byteCompleto), 32'd0);
    checkVal("arst.flagsB", {29'd0, rxB.erroParidade, rxB.erroQuadro, rxB.quebraDetectada}, 32'd0);
    setLine(0, 1'b1);
    waitCycles(3);
    reset = 1'b0;
    waitCycles(3 * CPB);
    checkVal("arst.noPulse", 32'(pulsesA - p0), 32'd0);
    checkVal("arst.noPulseB", 32'(pulsesB - pB), 32'd0);
    checkVal("arst.byteHold", 32'(rxA.byteCompleto), 32'd0);
    runFrame(0, "81post", 9'h081, 1'b0, 2'b11, 2);

    checkVal("pulseWidth", 32'(widthErr), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_rx_config.md
Name: uart_rx_config

Overview:
Parametrised UART receiver, next generation of the fixed 8N1 receiver in the FPGA serial interface. Data width, parity mode and stop-bit count are configurable. Adds parity-error, framing-error and break detection, plus an asynchronous reset. Sits between the serial input pin and the command decoder; each received frame is delivered as a one-cycle valid pulse.

Parameters:
CLOCKS_POR_BIT, 5209, clock cycles per serial bit (≥4); 5209 = 9600 baud at 50 MHz
BITS_DADOS, 8, data bits per frame, legal range 5..9
PARIDADE, 0, parity mode: 0 = none, 1 = odd, 2 = even
BITS_PARADA, 1, stop bits expected, 1 or 2

Ports:
clock  input  1  system clock; all logic on rising edge
reset  input  1  asynchronous, active-high reset
bitSerialAtual  input  1  raw serial line, idle high, asynchronous to clock
bitsEstaoRecebidos  output  1  one-cycle pulse: frame complete; other outputs valid this cycle
byteCompleto  output  BITS_DADOS  received data word, LSB = first data bit on the line
erroParidade  output  1  parity mismatch in the last frame (always 0 when PARIDADE=0)
erroQuadro  output  1  framing error: any stop-bit sample was 0 in the last frame
quebraDetectada  output  1  break in the last frame: all data, parity and stop samples were 0

Behaviour:
- Interface: one clock domain; reset is asynchronous and active-high. Ports are named clock and reset.
- Reset (asynchronous):
  - state → ESPERA; counters and bit index → 0.
  - bitsEstaoRecebidos, erroParidade, erroQuadro, quebraDetectada → 0; byteCompleto → 0.
  - Both synchroniser flops → 1.
  - Reset mid-frame abandons the frame silently; no pulse is emitted.
- Synchroniser: bitSerialAtual passes through 2 flops. All FSM decisions use the second flop (the synchronised line, "linha").
- Counter width is $clog2(CLOCKS_POR_BIT) bits. Bit index width covers 0..BITS_DADOS-1.
- FSM states:
  - ESPERA: counter and index cleared; linha=0 → INICIO.
  - INICIO: counter increments until it reaches (CLOCKS_POR_BIT-1)/2 (integer division).
    - If linha=0 at that count: counter ← 0, go to DADOS.
    - Otherwise: false start, return to ESPERA with no pulse and flags unchanged.
  - DADOS: counter counts 0..CLOCKS_POR_BIT-1. On the terminal count: shift register[index] ← linha, counter ← 0.
    - After index BITS_DADOS-1: go to PARIDADE_ST if PARIDADE≠0, else PARADA.
  - PARIDADE_ST: sample linha on the terminal count.
    - Error when XOR(data bits, sample) ≠ required value: 1 for odd, 0 for even.
  - PARADA: samples BITS_PARADA stop bits, each on its terminal count. Any 0 sample sets the pending framing error.
    - After the last stop sample, the next edge:
      - loads byteCompleto from the shift register;
      - updates all three flags from the pending values;
      - asserts bitsEstaoRecebidos;
      - enters LIMPEZA.
  - LIMPEZA: one cycle; bitsEstaoRecebidos returns to 0.
    - Break frame → ESPERA_ALTA; otherwise → ESPERA.
  - ESPERA_ALTA: wait until linha=1, then go to ESPERA. Prevents a held-low line from producing repeated frames.
  - Illegal state encodings go to ESPERA.
- Output timing: byteCompleto and all flags hold their values until the next pulse. Every pulse rewrites all three flags.
- Break condition: sets quebraDetectada=1 and erroQuadro=1 together.
- Pulse latency: the pulse occurs exactly 2 + (CLOCKS_POR_BIT-1)/2 + 1 + (N-1)·CLOCKS_POR_BIT + 1 cycles after a clean pin falling edge (±1 for synchroniser phase), where N = 1 + BITS_DADOS + (PARIDADE≠0) + BITS_PARADA.
- Back-to-back frames: a start bit immediately following the stop bit is captured. The FSM is back in ESPERA ≥ CLOCKS_POR_BIT/2 − 2 cycles before the next start edge.

Test Plan:
- Defaults with CLOCKS_POR_BIT=16: send 0xA5 8N1 → exactly one 1-cycle pulse, byteCompleto=0xA5, all flags 0, pulse within ±1 of the formula.
- PARIDADE=2, BITS_DADOS=7, BITS_PARADA=2: send 0x03 with parity bit 0, then 0x03 with parity bit 1 → first frame erroParidade=0, second frame erroParidade=1; byteCompleto=0x03 in both.
- Send 0x55 with stop bit driven 0, then 0x55 correctly → first frame erroQuadro=1 and quebraDetectada=0; second frame both flags 0.
- Low glitch of 4 cycles (< 8) on the idle line → no pulse, FSM returns to ESPERA; a following 0x3C frame is received correctly.
- Hold the line low for 20 bit times, then release → exactly one pulse with byteCompleto=0x00, quebraDetectada=1, erroQuadro=1; no further pulse until the line is high; a next frame 0x81 is received with flags 0.
- Assert reset during data bit 3 of a frame → all outputs 0 asynchronously, no pulse for the abandoned frame; a subsequent 0x81 is received correctly.
